// File: rtl/router_fifo.sv
// router_fifo: routes each input word by addr into a per-port output FIFO.
// Define ROUTER_FIFO_STATS_EN to add the drop_cnt / push_cnt statistics ports.
module router_fifo #(
  parameter int DATA_W     = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        din_en,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           din,
  output logic                        din_rdy,
  output logic                        addr_err,
  output logic [NUM_PORTS-1:0]        dout_vld,
  input  logic [NUM_PORTS-1:0]        dout_rdy,
  output logic [NUM_PORTS*DATA_W-1:0] dout
`ifdef ROUTER_FIFO_STATS_EN
  ,
  output logic [15:0]                 drop_cnt,
  output logic [NUM_PORTS*16-1:0]     push_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NSLOT = 1 << ADDR_W;

  logic             w_in_range;
  logic             w_xfer;
  logic [NSLOT-1:0] w_full_pad;
  logic             r_addr_err;

  assign w_in_range = (32'(addr) < 32'(NUM_PORTS));
  assign din_rdy    = !w_in_range || !w_full_pad[addr];
  assign w_xfer     = din_en && din_rdy;
  assign addr_err   = r_addr_err;

  // Unreachable address slots never report full.
  for (genvar j = NUM_PORTS; j < NSLOT; j++) begin : g_pad
    assign w_full_pad[j] = 1'b0;
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_push;
    logic              w_pop;

    assign w_push = w_xfer && w_in_range && (addr == ADDR_W'(i));
    assign w_pop  = dout_vld[i] && dout_rdy[i];

    assign dout_vld[i]   = (r_cnt != '0);
    assign w_full_pad[i] = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign dout[i*DATA_W +: DATA_W] = r_mem[r_rptr];

    // Storage is not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= din;
    end

    // Pointers and occupancy; reset overrides any push or pop.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        unique case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + CNT_W'(1);
          2'b01:   r_cnt <= r_cnt - CNT_W'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end

`ifdef ROUTER_FIFO_STATS_EN
    logic [15:0] r_push_cnt;

    assign push_cnt[i*16 +: 16] = r_push_cnt;

    // Saturating count of words accepted into this port.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_push_cnt <= '0;
      end else if (w_push && r_push_cnt != 16'hFFFF) begin
        r_push_cnt <= r_push_cnt + 16'd1;
      end
    end
`endif
  end

  // One-cycle error pulse after a word to a nonexistent port is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_xfer && !w_in_range;
    end
  end

`ifdef ROUTER_FIFO_STATS_EN
  logic [15:0] r_drop_cnt;

  assign drop_cnt = r_drop_cnt;

  // Saturating count of dropped out-of-range words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_xfer && !w_in_range && r_drop_cnt != 16'hFFFF) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed checks of router_fifo (4-port and 3-port builds).
// Statistics checks are active when ROUTER_FIFO_STATS_EN is defined.
module tb_router_fifo;

  logic         clk;
  logic         rst;

  logic         din_en;
  logic [1:0]   addr;
  logic [31:0]  din;
  logic         din_rdy;
  logic         addr_err;
  logic [3:0]   dout_vld;
  logic [3:0]   dout_rdy;
  logic [127:0] dout;

  logic         b_din_en;
  logic [1:0]   b_addr;
  logic [31:0]  b_din;
  logic         b_din_rdy;
  logic         b_addr_err;
  logic [2:0]   b_dout_vld;
  logic [2:0]   b_dout_rdy;
  logic [95:0]  b_dout;

`ifdef ROUTER_FIFO_STATS_EN
  logic [15:0]  drop_cnt;
  logic [63:0]  push_cnt;
  logic [15:0]  b_drop_cnt;
  logic [47:0]  b_push_cnt;
`endif

  router_fifo #(
    .DATA_W(32), .NUM_PORTS(4), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .rst(rst),
    .din_en(din_en), .addr(addr), .din(din),
    .din_rdy(din_rdy), .addr_err(addr_err),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout(dout)
`ifdef ROUTER_FIFO_STATS_EN
    , .drop_cnt(drop_cnt), .push_cnt(push_cnt)
`endif
  );

  router_fifo #(
    .DATA_W(32), .NUM_PORTS(3), .FIFO_DEPTH(4)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .din_en(b_din_en), .addr(b_addr), .din(b_din),
    .din_rdy(b_din_rdy), .addr_err(b_addr_err),
    .dout_vld(b_dout_vld), .dout_rdy(b_dout_rdy), .dout(b_dout)
`ifdef ROUTER_FIFO_STATS_EN
    , .drop_cnt(b_drop_cnt), .push_cnt(b_push_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sa(input int i);
    return dout[i*32 +: 32];
  endfunction

  logic [31:0] q0[$];
  logic [31:0] q3[$];

  initial begin
    logic [31:0] d;
    logic        r0;
    logic        r3;
    logic        erdy;
    int          sel;

    rst = 1'b1;
    din_en = 1'b0; addr = 2'd0; din = '0; dout_rdy = '0;
    b_din_en = 1'b0; b_addr = 2'd0; b_din = '0; b_dout_rdy = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_vld", dout_vld, 4'b0000);
    chk("rst_err", addr_err, 1'b0);
    chk("rst_rdy", din_rdy, 1'b1);
    chk("rst_b_vld", b_dout_vld, 3'b000);

    // single word to port 1, consumer ready
    din_en = 1'b1; addr = 2'd1; din = 32'hA1B2C3D4; dout_rdy = 4'hF;
    #1;
    chk("p1_rdy", din_rdy, 1'b1);
    @(negedge clk);
    din_en = 1'b0;
    chk("p1_vld", dout_vld, 4'b0010);
    chk("p1_data", sa(1), 32'hA1B2C3D4);
    @(negedge clk);
    chk("p1_pop", dout_vld, 4'b0000);

    // fill port 2 with consumers stalled
    dout_rdy = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      din_en = 1'b1; addr = 2'd2; din = 32'(k);
      #1;
      chk("fill_rdy", din_rdy, 1'b1);
      @(negedge clk);
    end
    din_en = 1'b0; addr = 2'd2;
    #1;
    chk("full_rdy2", din_rdy, 1'b0);
    chk("full_vld", dout_vld, 4'b0100);
    chk("full_head", sa(2), 32'd1);
    addr = 2'd0;
    #1;
    chk("full_rdy0", din_rdy, 1'b1);

    // stalled port 2 does not block port 0
    din_en = 1'b1; addr = 2'd0; din = 32'h0000_00AA;
    @(negedge clk);
    din_en = 1'b0;
    chk("indep_vld", dout_vld, 4'b0101);
    chk("indep_d0", sa(0), 32'h0000_00AA);

    // full port popping still refuses the push this cycle
    dout_rdy = 4'b0101;
    din_en = 1'b1; addr = 2'd2; din = 32'h87654321;
    #1;
    chk("fullpop_rdy", din_rdy, 1'b0);
    @(negedge clk);
    chk("retry_rdy", din_rdy, 1'b1);
    chk("ord_2", sa(2), 32'd2);
    chk("ord_vld", dout_vld, 4'b0100);
    @(negedge clk);
    din_en = 1'b0;
    chk("ord_3", sa(2), 32'd3);
    chk("ord_vld3", dout_vld[2], 1'b1);
    @(negedge clk);
    chk("ord_4", sa(2), 32'd4);
    @(negedge clk);
    chk("ord_5th", sa(2), 32'h87654321);
    @(negedge clk);
    chk("ord_empty", dout_vld, 4'b0000);

    // alternating pushes to ports 0 and 3, random consumers
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      chk("rnd_vld0", dout_vld[0], q0.size() != 0);
      if (q0.size() != 0) chk("rnd_d0", sa(0), q0[0]);
      chk("rnd_vld3", dout_vld[3], q3.size() != 0);
      if (q3.size() != 0) chk("rnd_d3", sa(3), q3[0]);
      sel = (c % 2 == 0) ? 0 : 3;
      d = $urandom;
      r0 = 1'($urandom_range(0, 1));
      r3 = 1'($urandom_range(0, 1));
      din_en = 1'b1; addr = 2'(sel); din = d;
      dout_rdy = {r3, 1'b0, 1'b0, r0};
      #1;
      erdy = (sel == 0) ? (q0.size() < 4) : (q3.size() < 4);
      chk("rnd_rdy", din_rdy, erdy);
      if (r0 && q0.size() != 0) void'(q0.pop_front());
      if (r3 && q3.size() != 0) void'(q3.pop_front());
      if (erdy) begin
        if (sel == 0) q0.push_back(d);
        else q3.push_back(d);
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("drn_vld0", dout_vld[0], q0.size() != 0);
      if (q0.size() != 0) chk("drn_d0", sa(0), q0[0]);
      chk("drn_vld3", dout_vld[3], q3.size() != 0);
      if (q3.size() != 0) chk("drn_d3", sa(3), q3[0]);
      din_en = 1'b0; dout_rdy = 4'hF;
      if (q0.size() != 0) void'(q0.pop_front());
      if (q3.size() != 0) void'(q3.pop_front());
    end
    @(negedge clk);
    chk("drn_empty", dout_vld, 4'b0000);

    // reset mid-stream discards buffered words
    dout_rdy = 4'h0;
    for (int k = 0; k < 3; k++) begin
      din_en = 1'b1; addr = 2'd1; din = 32'(16'h11 + k);
      @(negedge clk);
    end
    din_en = 1'b0;
    chk("pre_rst_vld", dout_vld, 4'b0010);
`ifdef ROUTER_FIFO_STATS_EN
    chk("pre_rst_pcnt1", push_cnt[31:16], 16'd4);
`endif
    rst = 1'b1; din_en = 1'b1; addr = 2'd1; din = 32'h14;
    @(negedge clk);
    rst = 1'b0; din_en = 1'b0;
    #1;
    chk("mid_rst_vld", dout_vld, 4'b0000);
    chk("mid_rst_rdy", din_rdy, 1'b1);
    chk("mid_rst_err", addr_err, 1'b0);
`ifdef ROUTER_FIFO_STATS_EN
    chk("mid_rst_pcnt", push_cnt, 64'd0);
    chk("mid_rst_dcnt", drop_cnt, 16'd0);
`endif

    // out-of-range address on the 3-port build
    b_din_en = 1'b1; b_addr = 2'd3; b_din = 32'hDEAD_BEEF;
    #1;
    chk("oor_rdy", b_din_rdy, 1'b1);
    chk("oor_err_pre", b_addr_err, 1'b0);
    @(negedge clk);
    b_din_en = 1'b0;
    chk("oor_err", b_addr_err, 1'b1);
    chk("oor_vld", b_dout_vld, 3'b000);
`ifdef ROUTER_FIFO_STATS_EN
    chk("oor_dcnt", b_drop_cnt, 16'd1);
`endif
    @(negedge clk);
    chk("oor_err_end", b_addr_err, 1'b0);
    chk("oor_vld_end", b_dout_vld, 3'b000);
    b_din_en = 1'b1; b_addr = 2'd2; b_din = 32'd5;
    @(negedge clk);
    b_din_en = 1'b0;
    chk("b_p2_vld", b_dout_vld, 3'b100);
    chk("b_p2_data", b_dout[95:64], 32'd5);
    chk("b_p2_err", b_addr_err, 1'b0);
`ifdef ROUTER_FIFO_STATS_EN
    chk("b_p2_pcnt", b_push_cnt[47:32], 16'd1);
    chk("b_p2_dcnt", b_drop_cnt, 16'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
- REQ-001: Parameter DATA_W, default 32, width of the data word.
- REQ-002: Parameter NUM_PORTS, default 4, number of output ports, range 2..16.
- REQ-003: Parameter FIFO_DEPTH, default 4, entries per output FIFO, power of 2, minimum 2.
- REQ-004: Derived constant ADDR_W = max(1, ceil(log2(NUM_PORTS))).
- REQ-005: Port clk, input, 1, sole clock; all state SHALL change on its rising edge only.
- REQ-006: Port rst, input, 1, reset, synchronous and active-high.
- REQ-007: Port din_en, input, 1, input word valid.
- REQ-008: Port addr, input, ADDR_W, destination port index for din.
- REQ-009: Port din, input, DATA_W, input data word.
- REQ-010: Port din_rdy, output, 1, router can accept the word currently presented.
- REQ-011: Port addr_err, output, 1, one-cycle pulse on an out-of-range address drop.
- REQ-012: Port dout_vld, output, NUM_PORTS, per-port output valid; bit i belongs to port i.
- REQ-013: Port dout_rdy, input, NUM_PORTS, per-port consumer ready.
- REQ-014: Port dout, output, NUM_PORTS*DATA_W, packed output data; port i occupies bits [i*DATA_W +: DATA_W].

Function
- REQ-015: Each output port SHALL have its own FIFO_DEPTH-entry FIFO, with an occupancy counter of width log2(FIFO_DEPTH)+1.
- REQ-016: Input transfer SHALL occur when din_en && din_rdy are both high at a clk edge.
- REQ-017: For an in-range address, din_rdy SHALL equal !full[addr]; it depends combinationally on addr and must not depend on din_en.
- REQ-018: A transfer SHALL write din into FIFO[addr]; the word SHALL appear on dout of that port with dout_vld high in the next cycle (1-cycle latency).
- REQ-019: dout_vld[i] SHALL equal !empty[i]; dout slice i SHALL show the head entry of FIFO i.
- REQ-020: Output pop SHALL occur when dout_vld[i] && dout_rdy[i]; data SHALL leave each port in FIFO order.
- REQ-021: All ports SHALL pop independently in the same cycle; a stalled port SHALL NOT block pushes to other ports.
- REQ-022: A push and a pop on the same non-full port in one cycle SHALL both complete, leaving occupancy unchanged.
- REQ-023: A full port SHALL deassert din_rdy even when it pops in the same cycle; the freed entry becomes usable in the next cycle.
- REQ-024: Read and write pointers SHALL wrap modulo FIFO_DEPTH.
- REQ-025: Address handling when addr >= NUM_PORTS:
  - din_rdy SHALL be 1;
  - a transfer SHALL discard the word;
  - addr_err SHALL pulse high for exactly the following cycle.
- REQ-026: dout slice contents while dout_vld[i]=0 SHALL be don't-care; the bench checks dout only when valid.

Reset
- REQ-027: While rst is high at a clk edge, all FIFOs SHALL empty: pointers and counters go to 0.
- REQ-028: One cycle after the reset edge, outputs SHALL be dout_vld=0 and addr_err=0, and din_rdy SHALL be 1.
- REQ-029: A transfer attempted while rst=1 SHALL be ignored; reset SHALL override any push or pop in the same cycle.
- REQ-030: Reset mid-stream SHALL discard all buffered words; FIFO storage contents need no reset.

Configuration
- REQ-031: Macro ROUTER_FIFO_STATS_EN, when defined, SHALL add output port drop_cnt (16 bits) and output port push_cnt (NUM_PORTS*16 bits).
  - drop_cnt counts addr_err events.
  - push_cnt counts accepted words per port.
  - All counters saturate at 16'hFFFF and clear on rst.
- REQ-032: Without ROUTER_FIFO_STATS_EN those ports and their counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
- REQ-033: Reset, then din_en=1, addr=1, din=32'hA1B2C3D4 for one cycle, all dout_rdy=1 -> next cycle dout_vld=4'b0010 and dout slice1=A1B2C3D4; slice popped, dout_vld=0 one cycle later.
- REQ-034: dout_rdy=0, push 4 words 1,2,3,4 to port 2 -> din_rdy=0 with addr=2 while still 1 with addr=0; set dout_rdy[2]=1 -> port 2 outputs 1,2,3,4 in order over 4 cycles.
- REQ-035: Port 2 full with dout_rdy[2]=1 and push 32'h87654321 offered -> rejected that cycle, accepted next cycle, later appears as 5th word.
- REQ-036: Alternating pushes to ports 0 and 3 with random dout_rdy for 1000 cycles -> per-port scoreboard matches, no loss, no duplication.
- REQ-037: Push 3 words to port 1, then assert rst for one cycle while pushing -> dout_vld=0 after reset; with stats enabled, push_cnt cleared.
- REQ-038: NUM_PORTS=3, addr=3 transfer -> din_rdy=1, addr_err pulses one cycle, no dout_vld change, drop_cnt=1 with ROUTER_FIFO_STATS_EN.
